fifo_sr_rd_stream: RTL and testbench
====================================

# fifo_sr_rd_stream

Read-side adapter sitting directly downstream of the shift-register FIFO. It turns the FIFO's pop/empty interface into a registered valid/ready stream with a two-entry output buffer. It issues pops only when it has space, so the consumer sees full one-per-cycle throughput under back-pressure with no combinational path from `out_ready` to `out_data`. It also provides a transfer counter, a synchronous flush and a sticky protocol-error flag.

## Interface
Parameters:
- `W`, 32, data width; must match the FIFO's `W`.
- `CW`, 16, width of the transfer counter.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fifo_empty_r`  in  1  FIFO empty status (registered in the FIFO).
- `fifo_pop_data`  in  W  FIFO head entry; combinationally valid while `fifo_empty_r`=0.
- `fifo_pop_data_valid_r`  in  1  FIFO pop echo, one cycle after each pop.
- `fifo_pop`  out  1  pop request to the FIFO.
- `out_valid_r`  out  1  stream valid; registered.
- `out_data`  out  W  stream data; a mux of buffer registers only.
- `out_ready`  in  1  consumer ready.
- `flush`  in  1  synchronous discard of buffered entries.
- `xfer_cnt_r`  out  CW  saturating count of stream transfers.
- `err_r`  out  1  sticky protocol error.

## Operation
- Buffer:
  - Two slots `slot[0..1]`, 1-bit write select `wsel_r`, 1-bit read select `rsel_r`, occupancy `cnt_r` in {0,1,2}.
  - `out_valid_r` equals (`cnt_r`≠0), held as its own flop and updated alongside `cnt_r`.
  - `out_data` = `slot[rsel_r]`.
- Transfer: `out_fire` = `out_valid_r` & `out_ready`.
- Pop rule: `fifo_pop` = ~`flush` & ~`fifo_empty_r` & (`cnt_r`≠2 | `out_ready`).
  - This is the only combinational path from `out_ready`.
  - No pop is issued while `fifo_empty_r`=1.
- On `fifo_pop`:
  - `slot[wsel_r]` ← `fifo_pop_data`, sampled in the same cycle.
  - `wsel_r` toggles.
- On `out_fire` with `flush`=0: `rsel_r` toggles.
- Occupancy: `cnt_r` next = `cnt_r` + `fifo_pop` − `out_fire`. Simultaneous pop and fire leave `cnt_r` unchanged.
- `flush`=1:
  - `cnt_r`, `wsel_r` and `rsel_r` ← 0; `out_valid_r` ← 0.
  - `fifo_pop` is forced to 0.
  - A coincident `out_fire` still counts in `xfer_cnt_r`; the consumer has taken the data.
  - FIFO contents are untouched.
- `xfer_cnt_r`:
  - Increments on every `out_fire`.
  - Saturates at 2^CW−1.
  - Cleared by `rst` only.
- `err_r`:
  - `pop_d_r` registers `fifo_pop`.
  - `err_r` is set when `fifo_pop_data_valid_r` ≠ `pop_d_r`.
  - Sticky until `rst`.
- Slot data registers are not reset; all control state is.

## Timing
- Reset values: `fifo_pop`=0 (since `cnt_r`=0 but `flush` and `fifo_empty_r` gate it, it follows the inputs combinationally), `out_valid_r`=0, `cnt_r`=0, `wsel_r`=`rsel_r`=0, `xfer_cnt_r`=0, `err_r`=0, `pop_d_r`=0.
- Reset may assert mid-transfer: buffered entries are lost and outputs return to reset values immediately.
- Latency: pop at cycle t gives the entry on `out_data` with `out_valid_r`=1 at t+1 when `cnt_r` was 0.
  - FIFO non-empty to stream valid: one cycle after `fifo_empty_r` falls.
- Throughput: one transfer per cycle sustained while the FIFO is non-empty and `out_ready`=1.
- Back-pressure:
  - `out_ready`=0 with a non-empty FIFO fills the buffer in two cycles, after which `fifo_pop`=0.
  - When `out_ready` returns, a pop occurs in the same cycle as the fire.
- Ordering: entries leave in exact FIFO order across every back-pressure pattern; no loss, no duplication.
- `out_valid_r` and `out_data` are stable while `out_valid_r`=1 and `out_ready`=0, unless `flush` asserts.
- FIFO drain: when the last entry is popped at t, `fifo_empty_r`=1 at t+1 and no pop is issued at t+1.

## Test plan
- Reset, FIFO holds 0xA, 0xB, 0xC, `out_ready`=1 → `out_data` 0xA, 0xB, 0xC on three consecutive cycles, first valid one cycle after the first pop; `xfer_cnt_r`=3; `err_r`=0.
- 4 entries, `out_ready`=0 for 5 cycles then 1 → exactly 2 pops, `cnt_r`=2, `out_data`=entry0 held stable; then 4 transfers back-to-back in order.
- Random `out_ready` (50%) over 1000 entries → scoreboard matches FIFO order; `xfer_cnt_r`=1000; `fifo_pop` never asserted while `fifo_empty_r`=1.
- `cnt_r`=2, assert `flush` for one cycle with `out_ready`=0 → next cycle `out_valid_r`=0, no pop that cycle, next pop resumes from the FIFO head.
- `CW`=4, 20 transfers → `xfer_cnt_r` holds 15.
- Drive `fifo_pop_data_valid_r`=1 with no preceding pop → `err_r`=1 next cycle, still set 100 cycles later, cleared only by `rst`.

Source files
------------

// File: rtl/fifo_sr_rd_stream.sv
// Registered valid/ready read adapter for the shift-register FIFO, two-entry skid buffer.
// Pop to out_valid_r in one cycle; pops only while a slot is free or one drains, so out_ready never reaches out_data.
module fifo_sr_rd_stream #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty_r,
    input  logic [W-1:0]  fifo_pop_data,
    input  logic          fifo_pop_data_valid_r,
    output logic          fifo_pop,
    output logic          out_valid_r,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    input  logic          flush,
    output logic [CW-1:0] xfer_cnt_r,
    output logic          err_r
);

    logic [W-1:0] slot [2];
    logic         wsel_r;
    logic         rsel_r;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_nxt;
    logic         pop_d_r;
    logic         out_fire;

    assign out_fire = out_valid_r & out_ready;
    assign fifo_pop = ~flush & ~fifo_empty_r & ((cnt_r != 2'd2) | out_ready);
    assign out_data = slot[rsel_r];
    assign cnt_nxt  = cnt_r + 2'(fifo_pop) - 2'(out_fire);

    // Data slots carry no reset; only the control state below does.
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            slot[wsel_r] <= fifo_pop_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel_r      <= 1'b0;
            rsel_r      <= 1'b0;
            cnt_r       <= 2'd0;
            out_valid_r <= 1'b0;
            pop_d_r     <= 1'b0;
            err_r       <= 1'b0;
            xfer_cnt_r  <= '0;
        end else begin
            if (flush) begin
                wsel_r      <= 1'b0;
                rsel_r      <= 1'b0;
                cnt_r       <= 2'd0;
                out_valid_r <= 1'b0;
            end else begin
                if (fifo_pop) begin
                    wsel_r <= ~wsel_r;
                end
                if (out_fire) begin
                    rsel_r <= ~rsel_r;
                end
                cnt_r       <= cnt_nxt;
                out_valid_r <= (cnt_nxt != 2'd0);
            end
            // The FIFO echoes every pop exactly one cycle later; any disagreement is sticky.
            pop_d_r <= fifo_pop;
            if (fifo_pop_data_valid_r != pop_d_r) begin
                err_r <= 1'b1;
            end
            // A fire coincident with flush still counts: the consumer took that word.
            if (out_fire && (xfer_cnt_r != {CW{1'b1}})) begin
                xfer_cnt_r <= xfer_cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_sr_rd_stream.sv
// Bench for fifo_sr_rd_stream: queue-based FIFO model upstream, transaction-level buffer model checked every cycle.
module tb_fifo_sr_rd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty_r;
    logic [31:0] fifo_pop_data;
    logic        fifo_pop_data_valid_r;
    logic        fifo_pop;
    logic        out_valid_r;
    logic [31:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [15:0] xfer_cnt_r;
    logic        err_r;

    logic        pop_s;
    logic        valid_s;
    logic [31:0] data_s;
    logic [3:0]  xfer_s;
    logic        err_s;

    logic        echo_r;
    logic        force_err;
    logic        ord_en;

    logic [31:0] q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mbuf[$];
    int unsigned fires;
    int unsigned npops;
    bit          exp_err;
    bit          last_pop;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_sr_rd_stream #(.W(32), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty_r(fifo_empty_r), .fifo_pop_data(fifo_pop_data),
        .fifo_pop_data_valid_r(fifo_pop_data_valid_r), .fifo_pop(fifo_pop),
        .out_valid_r(out_valid_r), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .xfer_cnt_r(xfer_cnt_r), .err_r(err_r)
    );

    fifo_sr_rd_stream #(.W(32), .CW(4)) u_sat (
        .clk(clk), .rst(rst),
        .fifo_empty_r(fifo_empty_r), .fifo_pop_data(fifo_pop_data),
        .fifo_pop_data_valid_r(fifo_pop_data_valid_r), .fifo_pop(pop_s),
        .out_valid_r(valid_s), .out_data(data_s), .out_ready(out_ready),
        .flush(flush), .xfer_cnt_r(xfer_s), .err_r(err_s)
    );

    assign fifo_pop_data_valid_r = echo_r | force_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [31:0] v);
        q.push_back(v);
        if (ord_en) exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream FIFO: registered empty flag and head, pop echo one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fifo_empty_r  <= 1'b1;
            fifo_pop_data <= '0;
            echo_r        <= 1'b0;
        end else begin
            if (fifo_pop && q.size() != 0) void'(q.pop_front());
            echo_r        <= fifo_pop;
            fifo_empty_r  <= (q.size() == 0);
            fifo_pop_data <= (q.size() != 0) ? q[0] : 32'd0;
        end
    end

    // Reference model: an ordered list of words popped but not yet delivered.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mbuf.delete();
            fires    = 0;
            npops    = 0;
            exp_err  = 1'b0;
            last_pop = 1'b0;
        end else begin
            if (out_valid_r && out_ready) begin
                fires++;
                if (ord_en) begin
                    chk("order", out_data, (exp_q.size() != 0) ? exp_q[0] : ~out_data);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (mbuf.size() != 0) void'(mbuf.pop_front());
            end
            if (fifo_pop) begin
                mbuf.push_back(fifo_pop_data);
                npops++;
            end
            if (flush) mbuf.delete();
            if (fifo_pop_data_valid_r != last_pop) exp_err = 1'b1;
            last_pop = fifo_pop;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic        ev;
            logic        ep;
            int unsigned e16;
            int unsigned e4;
            ev  = (mbuf.size() != 0);
            ep  = !flush && !fifo_empty_r && (mbuf.size() < 2 || out_ready);
            e16 = (fires > 65535) ? 65535 : fires;
            e4  = (fires > 15) ? 15 : fires;
            chk("occupancy", 64'(mbuf.size() <= 2), 64'd1);
            chk("out_valid", out_valid_r, ev);
            if (ev) chk("out_data", out_data, mbuf[0]);
            chk("pop_rule", fifo_pop, ep);
            chk("xfer_cnt", xfer_cnt_r, 64'(e16));
            chk("err", err_r, exp_err);
            chk("sat_valid", valid_s, ev);
            if (ev) chk("sat_data", data_s, mbuf[0]);
            chk("sat_pop", pop_s, ep);
            chk("sat_xfer", xfer_s, 64'(e4));
            chk("sat_err", err_s, exp_err);
        end
    end

    initial begin
        int cyc;
        int loaded;
        int unsigned p0;
        rst = 1'b1; out_ready = 1'b0; flush = 1'b0; force_err = 1'b0; ord_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid_r, 0);
        chk("rst_xfer", xfer_cnt_r, 0);
        chk("rst_err", err_r, 0);
        chk("rst_pop", fifo_pop, 0);
        rst = 1'b0;

        // Three entries streamed with out_ready held high.
        out_ready = 1'b1;
        push(32'hA); push(32'hB); push(32'hC);
        tick();
        chk("t1_pop", fifo_pop, 1);
        chk("t1_valid", out_valid_r, 0);
        tick(); chk("t1_d0", out_data, 32'hA); chk("t1_v0", out_valid_r, 1);
        tick(); chk("t1_d1", out_data, 32'hB);
        tick(); chk("t1_d2", out_data, 32'hC);
        tick();
        chk("t1_idle", out_valid_r, 0);
        chk("t1_xfer", xfer_cnt_r, 3);
        chk("t1_err", err_r, 0);

        // Back-pressure: two pops fill the buffer, then the head stays put.
        out_ready = 1'b0;
        p0 = npops;
        push(32'h10); push(32'h11); push(32'h12); push(32'h13);
        repeat (5) tick();
        chk("bp_pops", 64'(npops - p0), 2);
        chk("bp_pop_off", fifo_pop, 0);
        chk("bp_head", out_data, 32'h10);
        chk("bp_valid", out_valid_r, 1);
        out_ready = 1'b1;
        #1 chk("bp_pop_fire", fifo_pop, 1);
        tick(); chk("bp_d1", out_data, 32'h11);
        tick(); chk("bp_d2", out_data, 32'h12);
        tick(); chk("bp_d3", out_data, 32'h13);
        tick(); chk("bp_idle", out_valid_r, 0);
        chk("bp_xfer", xfer_cnt_r, 7);

        // Flush with a full buffer drops both slots; streaming resumes at the FIFO head.
        out_ready = 1'b0;
        push(32'h20); push(32'h21); push(32'h22); push(32'h23);
        repeat (3) tick();
        chk("fl_full_head", out_data, 32'h20);
        flush = 1'b1;
        #1 chk("fl_no_pop", fifo_pop, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", out_valid_r, 0);
        chk("fl_resume_pop", fifo_pop, 1);
        tick(); chk("fl_d0", out_data, 32'h22); chk("fl_v0", out_valid_r, 1);
        out_ready = 1'b1;
        tick(); chk("fl_d1", out_data, 32'h23);
        tick(); chk("fl_idle", out_valid_r, 0);
        chk("fl_xfer", xfer_cnt_r, 9);

        // Asynchronous reset in the middle of a transfer.
        out_ready = 1'b0;
        push(32'h30); push(32'h31);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid_r, 0);
        chk("arst_xfer", xfer_cnt_r, 0);
        chk("arst_pop", fifo_pop, 0);
        tick();
        rst = 1'b0;

        // Spurious pop echo sets a sticky error.
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        chk("err_set", err_r, 1);
        repeat (100) tick();
        chk("err_sticky", err_r, 1);
        rst = 1'b1;
        #1 chk("err_clear", err_r, 0);
        tick();
        rst = 1'b0;

        // Random feed and back-pressure over 1000 entries.
        ord_en = 1'b1;
        loaded = 0;
        cyc = 0;
        while (fires < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (loaded < 1000 && $urandom_range(0, 3) != 0) begin
                push($urandom);
                loaded++;
            end
            tick();
            cyc++;
        end
        ord_en = 1'b0;
        chk("rnd_delivered", 64'(fires), 1000);
        chk("rnd_xfer", xfer_cnt_r, 1000);
        chk("rnd_sat_xfer", xfer_s, 15);
        chk("rnd_err", err_r, 0);
        chk("rnd_leftover", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
